// File: rtl/sram_arb_pkg.sv
// Shared types for the multi-port SRAM arbiter: FSM state encoding and
// data-bus width.
package sram_arb_pkg;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // SRAM byte-lane strobes are active low, byte enables active high.
  function automatic logic [1:0] lanes_n(input logic [1:0] be_in);
    return ~be_in;
  endfunction
endpackage

// File: rtl/sram_arbiter_mp_rr_arbiter.sv
// Combinational round-robin picker: search starts at last_idx+1 and wraps,
// the first requesting port found wins.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] last_idx,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] p;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    p       = '0;
    for (int k = N; k >= 1; k--) begin
      p = IW'((int'(last_idx) + k) % N);
      if (req_vec[p]) begin
        gnt_vld = 1'b1;
        gnt_idx = p;
      end
    end
  end
endmodule

// File: rtl/sram_arbiter_mp.sv
// Multi-port async-SRAM arbiter: IDLE/SETUP/ACCESS/DONE sequencer with
// round-robin grant. Define SRAM_ARB_PORT0_PRIORITY_EN to give port 0 absolute priority.
module sram_arbiter_mp
  import sram_arb_pkg::*;
#(
  parameter int NPORTS        = 3,
  parameter int AW            = 19,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk200,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  output logic [NPORTS-1:0]    ack,
  input  logic [NPORTS-1:0]    read,
  input  logic [NPORTS*AW-1:0] address,
  input  logic [NPORTS*2-1:0]  be,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [DW-1:0]        rdata,
  output logic                 SR_OE_n,
  output logic                 SR_WE_n,
  output logic                 SR_LB_n,
  output logic                 SR_UB_n,
  output logic [AW-1:0]        SR_A,
  inout  wire  [DW-1:0]        SR_D
);
  localparam int          IW       = $clog2(NPORTS);
  localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);

  arb_state_e     state;
  logic [3:0]     cnt;
  logic [IW-1:0]  last_idx;
  logic [IW-1:0]  gnt;
  logic           op_rd;
  logic           d_oe;
  logic [DW-1:0]  d_out;

  logic [NPORTS-1:0] req_rr;
  logic              rr_vld;
  logic [IW-1:0]     rr_idx;
  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic              upd_ptr;

`ifdef SRAM_ARB_PORT0_PRIORITY_EN
  // Port 0 bypasses the rotation; the pointer only tracks ports 1..N-1.
  assign req_rr  = {req[NPORTS-1:1], 1'b0};
  assign win_vld = req[0] | rr_vld;
  assign win_idx = req[0] ? '0 : rr_idx;
  assign upd_ptr = ~req[0];
`else
  assign req_rr  = req;
  assign win_vld = rr_vld;
  assign win_idx = rr_idx;
  assign upd_ptr = 1'b1;
`endif

  rr_arbiter #(.N(NPORTS)) u_rr (
    .req_vec  (req_rr),
    .last_idx (last_idx),
    .gnt_vld  (rr_vld),
    .gnt_idx  (rr_idx)
  );

  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_be;
  logic [DW-1:0] sel_wd;
  logic          sel_rd;

  assign sel_addr = address[win_idx*AW +: AW];
  assign sel_be   = be[win_idx*2 +: 2];
  assign sel_wd   = wdata[win_idx*DW +: DW];
  assign sel_rd   = read[win_idx];

  assign SR_D = d_oe ? d_out : {DW{1'bz}};

  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_idx <= IW'(NPORTS - 1);
      gnt      <= '0;
      op_rd    <= 1'b0;
      d_oe     <= 1'b0;
      d_out    <= '0;
      ack      <= '0;
      rdata    <= '0;
      SR_OE_n  <= 1'b1;
      SR_WE_n  <= 1'b1;
      SR_LB_n  <= 1'b1;
      SR_UB_n  <= 1'b1;
      SR_A     <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            gnt   <= win_idx;
            op_rd <= sel_rd;
            SR_A  <= sel_addr;
            {SR_UB_n, SR_LB_n} <= lanes_n(sel_be);
            d_out <= sel_wd;
            d_oe  <= ~sel_rd;
            if (upd_ptr) last_idx <= win_idx;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt     <= '0;
          SR_OE_n <= ~op_rd;
          SR_WE_n <= op_rd;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt == LAST_CNT) begin
            // Strobe rises here so DONE sees both strobes high.
            SR_OE_n  <= 1'b1;
            SR_WE_n  <= 1'b1;
            if (op_rd) rdata <= SR_D;
            ack[gnt] <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: begin
          d_oe    <= 1'b0;
          SR_LB_n <= 1'b1;
          SR_UB_n <= 1'b1;
          cnt     <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter_mp.sv
// Bench for sram_arbiter_mp: directed and randomized transfers against an
// SRAM model plus a queue-free reference of memory contents and grant order.
module tb_sram_arbiter_mp;
  localparam int NP = 3, AW = 19, AC = 2;
  localparam int NP8 = 8, AC8 = 1;

  logic clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  logic                 reset;
  logic [NP-1:0]        req, ack, read;
  logic [NP*AW-1:0]     address;
  logic [NP*2-1:0]      be;
  logic [NP*16-1:0]     wdata;
  logic [15:0]          rdata;
  logic                 sr_oe_n, sr_we_n, sr_lb_n, sr_ub_n;
  logic [AW-1:0]        sr_a;
  tri   [15:0]          sr_d;
  pullup (sr_d);

  logic [NP8-1:0]       req8, ack8, read8;
  logic [NP8*AW-1:0]    address8;
  logic [NP8*2-1:0]     be8;
  logic [NP8*16-1:0]    wdata8;
  logic [15:0]          rdata8;
  logic                 oe8_n, we8_n, lb8_n, ub8_n;
  logic [AW-1:0]        a8;
  tri   [15:0]          d8;
  pullup (d8);

  sram_arbiter_mp #(.NPORTS(NP), .AW(AW), .ACCESS_CYCLES(AC)) dut (
    .clk200(clk200), .reset(reset), .req(req), .ack(ack), .read(read),
    .address(address), .be(be), .wdata(wdata), .rdata(rdata),
    .SR_OE_n(sr_oe_n), .SR_WE_n(sr_we_n), .SR_LB_n(sr_lb_n), .SR_UB_n(sr_ub_n),
    .SR_A(sr_a), .SR_D(sr_d));

  sram_arbiter_mp #(.NPORTS(NP8), .AW(AW), .ACCESS_CYCLES(AC8)) dut8 (
    .clk200(clk200), .reset(reset), .req(req8), .ack(ack8), .read(read8),
    .address(address8), .be(be8), .wdata(wdata8), .rdata(rdata8),
    .SR_OE_n(oe8_n), .SR_WE_n(we8_n), .SR_LB_n(lb8_n), .SR_UB_n(ub8_n),
    .SR_A(a8), .SR_D(d8));

  // SRAM device model: drives on OE low, stores enabled bytes while WE low.
  logic [15:0] mem [256];
  assign sr_d = (!sr_oe_n) ? mem[sr_a[7:0]] : 16'bz;
  always @(posedge clk200) begin
    if (!sr_we_n) begin
      if (!sr_lb_n) mem[sr_a[7:0]][7:0]  <= sr_d[7:0];
      if (!sr_ub_n) mem[sr_a[7:0]][15:8] <= sr_d[15:8];
    end
  end

  // Reference state: expected memory image, expected rdata, rr pointer.
  logic [15:0] exp_mem [256];
  logic [15:0] exp_rdata;
  int          ptr;
  int          checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_grant(input logic [NP-1:0] pend);
`ifdef SRAM_ARB_PORT0_PRIORITY_EN
    if (pend[0]) return 0;
    for (int k = 1; k <= NP; k++)
      if (((ptr + k) % NP) != 0 && pend[(ptr + k) % NP]) return (ptr + k) % NP;
`else
    for (int k = 1; k <= NP; k++)
      if (pend[(ptr + k) % NP]) return (ptr + k) % NP;
`endif
    return -1;
  endfunction

  task automatic model_commit(input int g);
`ifdef SRAM_ARB_PORT0_PRIORITY_EN
    if (g != 0) ptr = g;
`else
    ptr = g;
`endif
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Single-requester transfer, started in an IDLE cycle; returns in IDLE.
  task automatic xfer(input int p, input bit rd, input logic [18:0] a,
                      input logic [1:0] b, input logic [15:0] wd);
    int lo = 0;
    req[p] = 1'b1; read[p] = rd;
    address[p*AW +: AW] = a; be[p*2 +: 2] = b; wdata[p*16 +: 16] = wd;
    for (int c = 1; c <= AC + 2; c++) begin
      @(posedge clk200); #1;
      if (rd ? !sr_oe_n : !sr_we_n) begin
        lo++;
        check("access_addr", 32'(sr_a), 32'(a));
        check("access_lanes", {30'd0, sr_ub_n, sr_lb_n}, {30'd0, ~b});
        if (!rd) check("access_wdata", 32'(sr_d), 32'(wd));
      end
      if (c < AC + 2) check("ack_early", 32'(ack), 32'd0);
    end
    check("ack_port", 32'(ack), 32'(1) << p);
    check("done_strobes", {30'd0, sr_oe_n, sr_we_n}, 32'd3);
    check("strobe_len", lo, AC);
    if (rd) begin
      exp_rdata = exp_mem[a[7:0]];
    end else begin
      check("done_wdata", 32'(sr_d), 32'(wd));
      if (b[0]) exp_mem[a[7:0]][7:0]  = wd[7:0];
      if (b[1]) exp_mem[a[7:0]][15:8] = wd[15:8];
    end
    check("rdata", 32'(rdata), 32'(exp_rdata));
    model_commit(p);
    req[p] = 1'b0;
    @(posedge clk200); #1;
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_bus_z", 32'(sr_d), 32'hFFFF);
  endtask

  // Several simultaneous readers; each drops req on its ack.
  task automatic contend(input logic [NP-1:0] v);
    logic [NP-1:0] pend = v;
    int budget = 100;
    int g, ai;
    for (int p = 0; p < NP; p++) begin
      read[p] = 1'b1; address[p*AW +: AW] = 19'h10000 | 19'(p); be[p*2 +: 2] = 2'b11;
    end
    req = v;
    while (pend != 0 && budget > 0) begin
      @(posedge clk200); #1;
      budget--;
      if (ack != 0) begin
        g = model_grant(pend);
        check("rr_grant", 32'(ack), 32'(1) << g);
        ai = onehot_idx(ack);
        exp_rdata = exp_mem[8'(ai)];
        check("rr_rdata", 32'(rdata), 32'(exp_rdata));
        model_commit(ai);
        pend[ai] = 1'b0;
        req[ai] = 1'b0;
      end
    end
    check("rr_timeout", 32'(pend), 32'd0);
    req = '0;
    @(posedge clk200); #1;
  endtask

  initial begin
    int exp_seq [4];
    logic [NP-1:0] v;
    int got, budget;
`ifdef SRAM_ARB_PORT0_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 0};
`endif
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0; exp_mem[i] = 16'h0; end
    exp_rdata = 16'h0;
    ptr = NP - 1;
    req = '0; read = '0; address = '0; be = '0; wdata = '0;
    req8 = '0; read8 = '0; address8 = '0; be8 = '0; wdata8 = '0;
    reset = 1'b1;
    #1;
    check("rst_strobes", {28'd0, sr_oe_n, sr_we_n, sr_lb_n, sr_ub_n}, 32'hF);
    check("rst_addr", 32'(sr_a), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_bus_z", 32'(sr_d), 32'hFFFF);
    @(posedge clk200); @(posedge clk200); #1;
    reset = 1'b0;

    // All three request continuously from reset.
    for (int p = 0; p < NP; p++) begin
      read[p] = 1'b1; address[p*AW +: AW] = 19'h10000 | 19'(p); be[p*2 +: 2] = 2'b11;
    end
    req = 3'b111;
    got = 0; budget = 60;
    while (got < 4 && budget > 0) begin
      @(posedge clk200); #1;
      budget--;
      if (ack != 0) begin
        check("rr_order", 32'(ack), 32'(1) << exp_seq[got]);
        model_commit(exp_seq[got]);
        got++;
        if (got == 4) req = '0;
      end
    end
    check("rr_order_timeout", got, 4);
    @(posedge clk200); #1;

    // Directed transfers.
    xfer(1, 1'b0, 19'h01234, 2'b11, 16'hBEEF);
    xfer(2, 1'b1, 19'h01234, 2'b11, 16'h0000);
    check("read_beef", 32'(rdata), 32'hBEEF);
    xfer(0, 1'b0, 19'h01234, 2'b10, 16'hA55A);
    xfer(1, 1'b1, 19'h01234, 2'b11, 16'h0000);
    check("read_upper_only", 32'(rdata), 32'hA5EF);
    xfer(2, 1'b0, 19'h10005, 2'b11, 16'h4321);
    xfer(0, 1'b0, 19'h10005, 2'b00, 16'h1111);
    xfer(1, 1'b1, 19'h10005, 2'b11, 16'h0000);
    check("be_zero_keeps", 32'(rdata), 32'h4321);

    // Randomized single transfers and contention rounds.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] wd;
      wd = 16'($urandom);
      if (wd == 16'hFFFF) wd = 16'h0F0F;
      xfer($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)),
           19'h10000 | 19'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), wd);
    end
    for (int i = 0; i < 8; i++) begin
      v = NP'($urandom_range(1, 7));
      contend(v);
    end

    // Reset in the second ACCESS cycle of a write.
    req[0] = 1'b1; read[0] = 1'b0; address[0 +: AW] = 19'h000F0;
    be[1:0] = 2'b11; wdata[15:0] = 16'h1357;
    @(posedge clk200); @(posedge clk200); @(posedge clk200); #1;
    check("pre_abort_we", 32'(sr_we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_we", 32'(sr_we_n), 32'd1);
    check("abort_oe", 32'(sr_oe_n), 32'd1);
    check("abort_bus_z", 32'(sr_d), 32'hFFFF);
    check("abort_ack", 32'(ack), 32'd0);
    req = '0;
    @(posedge clk200); #1;
    reset = 1'b0;
    ptr = NP - 1;
    exp_rdata = 16'h0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk200); #1;
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    contend(3'b110);

    // Eight-port instance, one access cycle.
    req8[7] = 1'b1; read8[7] = 1'b0; address8[7*AW +: AW] = 19'h00077;
    be8[15:14] = 2'b11; wdata8[7*16 +: 16] = 16'h7777;
    for (int c = 1; c <= AC8 + 2; c++) begin
      @(posedge clk200); #1;
      if (c < AC8 + 2) check("p8_ack_early", 32'(ack8), 32'd0);
    end
    check("p8_ack7", 32'(ack8), 32'h80);
    req8 = '0;
    @(posedge clk200); #1;
    req8 = 8'b1000_0110;
    req8[0] = 1'b1;
    got = 0; budget = 10;
    while (got == 0 && budget > 0) begin
      @(posedge clk200); #1;
      budget--;
      if (ack8 != 0) begin
        check("p8_wrap", 32'(ack8), 32'h01);
        got = 1;
      end
    end
    check("p8_wrap_timeout", got, 1);
    req8 = '0;
    @(posedge clk200); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
